// File: rtl/fpu_pipe_ctrl_if.sv
// Request, pipeline and response channels between a requester, the FPU
// pipeline controller and the non-stallable FPU unit.
interface fpu_pipe_ctrl_if #(
    parameter int TAG_W = 5
);
    // valid/ready: a beat transfers on a rising edge where both are high;
    // valid never waits on ready. pipe_* toward the unit has no ready.
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_x1;
    logic [31:0]       req_x2;
    logic [TAG_W-1:0]  req_tag;

    logic              pipe_valid;
    logic [31:0]       pipe_x1;
    logic [31:0]       pipe_x2;
    logic              pipe_out_valid;
    logic [31:0]       pipe_y;
    logic              pipe_ovf;
    logic              pipe_unf;

    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_y;
    logic              resp_ovf;
    logic              resp_unf;
    logic [TAG_W-1:0]  resp_tag;

    modport master (
        output req_valid, req_x1, req_x2, req_tag,
        input  req_ready,
        input  pipe_valid, pipe_x1, pipe_x2,
        output pipe_out_valid, pipe_y, pipe_ovf, pipe_unf,
        input  resp_valid, resp_y, resp_ovf, resp_unf, resp_tag,
        output resp_ready
    );

    modport slave (
        input  req_valid, req_x1, req_x2, req_tag,
        output req_ready,
        output pipe_valid, pipe_x1, pipe_x2,
        input  pipe_out_valid, pipe_y, pipe_ovf, pipe_unf,
        output resp_valid, resp_y, resp_ovf, resp_unf, resp_tag,
        input  resp_ready
    );
endinterface

// File: rtl/fpu_pipe_ctrl.sv
// Issue/collect controller for a fixed-latency, non-stallable FPU pipeline:
// tags ride in a FIFO alongside the unit, results are buffered under a credit limit.
module fpu_pipe_ctrl #(
    parameter int TAG_W = 5,
    parameter int DEPTH = 8
) (
    input  logic                     sys_clk,
    input  logic                     rstn,
    fpu_pipe_ctrl_if.slave           bus,
    output logic                     busy,
    output logic                     err_orphan,
    output logic [$clog2(DEPTH):0]   credit
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int RW = 32 + 2 + TAG_W;

    logic             req_acc;
    logic             resp_acc;
    logic             tag_empty;
    logic             tag_pop;
    logic             res_empty;

    logic [TAG_W-1:0] tag_mem [DEPTH];
    logic [PW-1:0]    tag_wp;
    logic [PW-1:0]    tag_rp;
    logic [CW-1:0]    tag_cnt;

    logic [RW-1:0]    res_mem [DEPTH];
    logic [PW-1:0]    res_wp;
    logic [PW-1:0]    res_rp;
    logic [CW-1:0]    res_cnt;

    // Credit covers everything between accept and response pop, so neither
    // FIFO can overflow even though the unit never stalls.
    assign bus.req_ready = (credit != CW'(DEPTH));
    assign req_acc       = bus.req_valid & bus.req_ready;
    assign tag_empty     = (tag_cnt == '0);
    assign tag_pop       = bus.pipe_out_valid & ~tag_empty;
    assign res_empty     = (res_cnt == '0);
    assign bus.resp_valid = ~res_empty;
    assign resp_acc      = bus.resp_valid & bus.resp_ready;

    assign {bus.resp_y, bus.resp_ovf, bus.resp_unf, bus.resp_tag} = res_mem[res_rp];

    assign busy = (credit != '0) | bus.pipe_valid;

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            credit <= '0;
        end else begin
            case ({req_acc, resp_acc})
                2'b10:   credit <= credit + CW'(1);
                2'b01:   credit <= credit - CW'(1);
                default: credit <= credit;
            endcase
        end
    end

    // Issue register: operands hold when idle so the unit sees stable inputs.
    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            bus.pipe_valid <= 1'b0;
            bus.pipe_x1    <= '0;
            bus.pipe_x2    <= '0;
        end else begin
            bus.pipe_valid <= req_acc;
            if (req_acc) begin
                bus.pipe_x1 <= bus.req_x1;
                bus.pipe_x2 <= bus.req_x2;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (req_acc) begin
            tag_mem[tag_wp] <= bus.req_tag;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            tag_wp  <= '0;
            tag_rp  <= '0;
            tag_cnt <= '0;
        end else begin
            if (req_acc) tag_wp <= tag_wp + PW'(1);
            if (tag_pop) tag_rp <= tag_rp + PW'(1);
            case ({req_acc, tag_pop})
                2'b10:   tag_cnt <= tag_cnt + CW'(1);
                2'b01:   tag_cnt <= tag_cnt - CW'(1);
                default: tag_cnt <= tag_cnt;
            endcase
        end
    end

    // Results come back in issue order, so the tag FIFO head belongs to them.
    always_ff @(posedge sys_clk) begin
        if (tag_pop) begin
            res_mem[res_wp] <= {bus.pipe_y, bus.pipe_ovf, bus.pipe_unf, tag_mem[tag_rp]};
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            res_wp  <= '0;
            res_rp  <= '0;
            res_cnt <= '0;
        end else begin
            if (tag_pop)  res_wp <= res_wp + PW'(1);
            if (resp_acc) res_rp <= res_rp + PW'(1);
            case ({tag_pop, resp_acc})
                2'b10:   res_cnt <= res_cnt + CW'(1);
                2'b01:   res_cnt <= res_cnt - CW'(1);
                default: res_cnt <= res_cnt;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            err_orphan <= 1'b0;
        end else if (bus.pipe_out_valid & tag_empty) begin
            err_orphan <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fpu_pipe_ctrl.sv
// Bench for fpu_pipe_ctrl: a fixed-latency fdiv unit model, directed and random
// traffic, and a queue-based scoreboard of outstanding operations.
module tb_fpu_pipe_ctrl;
  localparam int TAG_W = 5;
  localparam int DEPTH = 8;
  localparam int L     = 4;
  localparam int EW    = 32 + 2 + TAG_W;

  logic       sys_clk = 1'b0;
  logic       rstn    = 1'b0;
  logic       busy;
  logic       err_orphan;
  logic [3:0] credit;
  logic       force_orphan = 1'b0;

  int total = 0;
  int bad   = 0;
  int n_resp = 0;

  fpu_pipe_ctrl_if #(.TAG_W(TAG_W)) bus();

  fpu_pipe_ctrl #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .sys_clk    (sys_clk),
    .rstn       (rstn),
    .bus        (bus),
    .busy       (busy),
    .err_orphan (err_orphan),
    .credit     (credit)
  );

  // ---------------- clock / reset ----------------
  always #5 sys_clk = ~sys_clk;

  // ---------------- reference arithmetic ----------------
  // Truncating single-precision divide for normal operands; returns {y, ovf, unf}.
  function automatic logic [33:0] fdiv(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] ma;
    logic [47:0] mb;
    logic [47:0] q;
    int          e;
    logic        s;
    logic [31:0] y;
    logic        ovf;
    logic        unf;
    s  = a[31] ^ b[31];
    ma = {24'd0, 1'b1, a[22:0]};
    mb = {24'd0, 1'b1, b[22:0]};
    e  = int'(a[30:23]) - int'(b[30:23]) + 127;
    q  = (ma << 23) / mb;
    if (q[23] == 1'b0) begin
      q = (ma << 24) / mb;
      e = e - 1;
    end
    ovf = (e >= 255);
    unf = (e <= 0);
    if (ovf)      y = {s, 8'hFF, 23'd0};
    else if (unf) y = {s, 31'd0};
    else          y = {s, e[7:0], q[22:0]};
    return {y, ovf, unf};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    r = {1'($urandom_range(0, 1)), 8'($urandom_range(64, 190)), 23'($urandom)};
    return r;
  endfunction

  // ---------------- FPU unit model (L stages, shares rstn) ----------------
  logic [L-1:0] st_v;
  logic [33:0]  st_d [L];

  always_ff @(posedge sys_clk) begin
    if (!rstn) st_v <= '0;
    else       st_v <= {st_v[L-2:0], bus.pipe_valid};
    st_d[0] <= fdiv(bus.pipe_x1, bus.pipe_x2);
    for (int i = 1; i < L; i++) st_d[i] <= st_d[i-1];
  end

  assign bus.pipe_out_valid = st_v[L-1] | force_orphan;
  assign bus.pipe_y         = st_d[L-1][33:2];
  assign bus.pipe_ovf       = st_d[L-1][1];
  assign bus.pipe_unf       = st_d[L-1][0];

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic          prev_acc = 1'b0;
  logic [31:0]   prev_x1;
  logic [31:0]   prev_x2;

  always @(negedge sys_clk) begin
    logic [EW-1:0] e;
    if (!rstn) begin
      exp_q.delete();
      prev_acc = 1'b0;
    end else begin
      check("credit", 64'(credit), 64'(exp_q.size()));
      check("req_ready", 64'(bus.req_ready), 64'(exp_q.size() != DEPTH));
      check("pipe_valid", 64'(bus.pipe_valid), 64'(prev_acc));
      check("busy", 64'(busy), 64'((exp_q.size() != 0) || prev_acc));
      if (prev_acc) begin
        check("pipe_x1", 64'(bus.pipe_x1), 64'(prev_x1));
        check("pipe_x2", 64'(bus.pipe_x2), 64'(prev_x2));
      end
      if (bus.resp_valid && bus.resp_ready) begin
        if (exp_q.size() == 0) begin
          check("resp_unexpected", 64'(bus.resp_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("resp_y", 64'(bus.resp_y), 64'(e[EW-1:TAG_W+2]));
          check("resp_ovf", 64'(bus.resp_ovf), 64'(e[TAG_W+1]));
          check("resp_unf", 64'(bus.resp_unf), 64'(e[TAG_W]));
          check("resp_tag", 64'(bus.resp_tag), 64'(e[TAG_W-1:0]));
          n_resp++;
        end
      end
      prev_acc = bus.req_valid && bus.req_ready;
      if (prev_acc) begin
        exp_q.push_back({fdiv(bus.req_x1, bus.req_x2), bus.req_tag});
        prev_x1 = bus.req_x1;
        prev_x2 = bus.req_x2;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drive_req(input logic [31:0] x1, input logic [31:0] x2, input logic [TAG_W-1:0] tag);
    bus.req_valid = 1'b1;
    bus.req_x1    = x1;
    bus.req_x2    = x2;
    bus.req_tag   = tag;
  endtask

  task automatic idle_req();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp(input string name, input int budget, output int n);
    n = 0;
    while (!bus.resp_valid && n < budget) begin
      cyc();
      n++;
    end
    if (!bus.resp_valid) check(name, 64'(bus.resp_valid), 64'd1);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    bus.resp_ready = 1'b1;
    idle_req();
    while ((busy || bus.resp_valid) && k < 40) begin
      cyc();
      k++;
    end
    check(name, 64'(busy), 64'd0);
  endtask

  task automatic issue_n(input int n, input int tag0);
    for (int i = 0; i < n; i++) begin
      drive_req(rand_fp(), rand_fp(), TAG_W'(tag0 + i));
      cyc();
    end
    idle_req();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n;
    int cnt;
    int base;

    bus.req_valid  = 1'b0;
    bus.req_x1     = '0;
    bus.req_x2     = '0;
    bus.req_tag    = '0;
    bus.resp_ready = 1'b0;

    // reset state
    rstn = 1'b0;
    cyc();
    cyc();
    rstn = 1'b1;
    check("rst_pipe_valid", 64'(bus.pipe_valid), 64'd0);
    check("rst_pipe_x1", 64'(bus.pipe_x1), 64'd0);
    check("rst_pipe_x2", 64'(bus.pipe_x2), 64'd0);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err_orphan", 64'(err_orphan), 64'd0);
    check("rst_credit", 64'(credit), 64'd0);
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);

    // single op: 3.0 / 2.0, tag 3
    bus.resp_ready = 1'b1;
    drive_req(32'h40400000, 32'h40000000, 5'd3);
    cyc();
    idle_req();
    check("single_pipe_valid", 64'(bus.pipe_valid), 64'd1);
    check("single_pipe_x1", 64'(bus.pipe_x1), 64'h40400000);
    wait_resp("single_timeout", 20, n);
    check("single_latency", 64'(n + 1), 64'(1 + L + 1));
    check("single_y", 64'(bus.resp_y), 64'h3FC00000);
    check("single_tag", 64'(bus.resp_tag), 64'd3);
    check("single_flags", 64'({bus.resp_ovf, bus.resp_unf}), 64'd0);
    cyc();
    check("single_busy_low", 64'(busy), 64'd0);

    // streaming: 20 back-to-back requests
    base = n_resp;
    cnt  = 0;
    for (int i = 0; i < 20; i++) begin
      drive_req(rand_fp(), rand_fp(), TAG_W'(i % 32));
      check("stream_req_ready", 64'(bus.req_ready), 64'd1);
      cyc();
      if (bus.pipe_valid) cnt++;
    end
    idle_req();
    check("stream_pipe_valid_cycles", 64'(cnt), 64'd20);
    cyc();
    check("stream_pipe_valid_end", 64'(bus.pipe_valid), 64'd0);
    drain("stream_drain");
    check("stream_resp_count", 64'(n_resp - base), 64'd20);

    // backpressure: 12 offered, DEPTH accepted
    bus.resp_ready = 1'b0;
    base = n_resp;
    cnt  = 0;
    for (int i = 0; i < 12; i++) begin
      drive_req(rand_fp(), rand_fp(), TAG_W'(i));
      if (bus.req_ready) cnt++;
      cyc();
    end
    idle_req();
    check("bp_accepted", 64'(cnt), 64'(DEPTH));
    for (int i = 0; i < L + 2; i++) cyc();
    check("bp_req_ready_low", 64'(bus.req_ready), 64'd0);
    check("bp_credit_full", 64'(credit), 64'(DEPTH));
    bus.resp_ready = 1'b1;
    check("bp_ready_before_pop", 64'(bus.req_ready), 64'd0);
    cyc();
    check("bp_ready_after_pop", 64'(bus.req_ready), 64'd1);
    drain("bp_drain");
    check("bp_resp_count", 64'(n_resp - base), 64'(DEPTH));

    // simultaneous accept and pop at credit DEPTH-1 and DEPTH
    bus.resp_ready = 1'b0;
    issue_n(DEPTH - 1, 20);
    for (int i = 0; i < L + 3; i++) cyc();
    check("sim_credit_7", 64'(credit), 64'(DEPTH - 1));
    drive_req(rand_fp(), rand_fp(), 5'd27);
    bus.resp_ready = 1'b1;
    cyc();
    check("sim_credit_hold", 64'(credit), 64'(DEPTH - 1));
    bus.resp_ready = 1'b0;
    drive_req(rand_fp(), rand_fp(), 5'd28);
    cyc();
    idle_req();
    check("sim_credit_full", 64'(credit), 64'(DEPTH));
    for (int i = 0; i < L + 2; i++) cyc();
    drive_req(rand_fp(), rand_fp(), 5'd29);
    bus.resp_ready = 1'b1;
    cyc();
    check("sim_full_pop", 64'(credit), 64'(DEPTH - 1));
    cyc();
    check("sim_accept_pop", 64'(credit), 64'(DEPTH - 1));
    drain("sim_drain");

    // overflow and underflow flags
    drive_req(32'h7F000000, 32'h00800000, 5'd9);
    cyc();
    idle_req();
    wait_resp("ovf_timeout", 20, n);
    check("ovf_flag", 64'(bus.resp_ovf), 64'd1);
    check("ovf_tag", 64'(bus.resp_tag), 64'd9);
    check("ovf_y", 64'(bus.resp_y), 64'h7F800000);
    drain("ovf_drain");
    drive_req(32'h00800000, 32'h7F000000, 5'd10);
    cyc();
    idle_req();
    wait_resp("unf_timeout", 20, n);
    check("unf_flag", 64'(bus.resp_unf), 64'd1);
    check("unf_tag", 64'(bus.resp_tag), 64'd10);
    drain("unf_drain");

    // orphan result with nothing outstanding
    force_orphan = 1'b1;
    cyc();
    force_orphan = 1'b0;
    check("orphan_flag", 64'(err_orphan), 64'd1);
    check("orphan_no_resp", 64'(bus.resp_valid), 64'd0);
    for (int i = 0; i < 3; i++) cyc();
    check("orphan_sticky", 64'(err_orphan), 64'd1);
    check("orphan_still_no_resp", 64'(bus.resp_valid), 64'd0);

    // reset with 3 buffered and 5 in flight
    bus.resp_ready = 1'b0;
    issue_n(3, 1);
    for (int i = 0; i < L + 3; i++) cyc();
    check("mid_buffered", 64'(credit), 64'd3);
    for (int i = 0; i < 5; i++) begin
      drive_req(rand_fp(), rand_fp(), TAG_W'(11 + i));
      cyc();
    end
    idle_req();
    rstn = 1'b0;
    cyc();
    rstn = 1'b1;
    check("mid_rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("mid_rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_credit", 64'(credit), 64'd0);
    check("mid_rst_orphan_clr", 64'(err_orphan), 64'd0);
    for (int i = 0; i < L + 3; i++) begin
      cyc();
      check("mid_no_stale", 64'({bus.resp_valid, err_orphan}), 64'd0);
    end
    bus.resp_ready = 1'b1;
    drive_req(32'h40400000, 32'h40000000, 5'd21);
    cyc();
    idle_req();
    wait_resp("fresh_timeout", 20, n);
    check("fresh_tag", 64'(bus.resp_tag), 64'd21);
    check("fresh_y", 64'(bus.resp_y), 64'h3FC00000);
    drain("fresh_drain");

    // random traffic with random backpressure
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0) drive_req(rand_fp(), rand_fp(), TAG_W'($urandom));
      else idle_req();
      bus.resp_ready = ($urandom_range(0, 2) != 0);
      cyc();
    end
    drain("rand_drain");
    check("final_credit", 64'(credit), 64'd0);
    check("final_orphan", 64'(err_orphan), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    bad++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
